// File: rtl/cpu_sdram_pkg.sv
// Shared definitions for the CPU-to-SDRAM half-word bridge.
package cpu_sdram_pkg;

  // Default CPU word-address width (21 bits -> 8 MB of 16-bit SDRAM).
  localparam int CPU_AW_DEFAULT = 21;

  // Half-word selector appended below the CPU word address.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Read beat counter values.
  localparam logic [1:0] BEAT_FIRST  = 2'd0;
  localparam logic [1:0] BEAT_SECOND = 2'd1;

  // Bridge sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_LO   = 3'd1,
    ST_WR_HI   = 3'd2,
    ST_RD_LO   = 3'd3,
    ST_RD_HI   = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

endpackage

// File: rtl/cpu_sdram_bridge.sv
// Splits single-outstanding 32-bit CPU word requests into two 16-bit
// Avalon-MM transfers and reassembles read data into one 32-bit response.
module cpu_sdram_bridge
  import cpu_sdram_pkg::*;
#(
  parameter int CPU_AW = CPU_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [CPU_AW-1:0] cpu_req_addr,
  input  logic [31:0]       cpu_req_wdata,
  input  logic [3:0]        cpu_req_be,
  output logic              cpu_resp_valid,
  output logic [31:0]       cpu_resp_rdata,
  output logic [CPU_AW:0]   avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  state_t              state_r;
  state_t              state_s;
  logic [CPU_AW-1:0]   req_addr_r;
  logic [31:0]         req_wdata_r;
  logic [3:0]          req_be_r;
  logic [1:0]          beat_cnt_r;
  logic [31:0]         rdata_r;
  logic                in_read_s;
  logic                capture_s;
  logic                last_beat_s;

  // Read beats are only honoured while a read is in progress; anything
  // else (e.g. beats still in flight from a read cut short by reset) is dropped.
  assign in_read_s   = (state_r == ST_RD_LO) || (state_r == ST_RD_HI) ||
                       (state_r == ST_RD_WAIT);
  assign capture_s   = in_read_s && avm_readdatavalid;
  assign last_beat_s = capture_s && (beat_cnt_r == BEAT_SECOND);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode from the current state, latched request and Avalon handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req_valid) begin
          if (cpu_req_we) begin
            if (cpu_req_be[1:0] != 2'b00) begin
              state_s = ST_WR_LO;
            end else if (cpu_req_be[3:2] != 2'b00) begin
              state_s = ST_WR_HI;
            end else begin
              state_s = ST_RESP;
            end
          end else begin
            state_s = ST_RD_LO;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_LO: begin
        if (avm_waitrequest) begin
          state_s = ST_WR_LO;
        end else if (req_be_r[3:2] != 2'b00) begin
          state_s = ST_WR_HI;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_WR_HI: begin
        if (avm_waitrequest) begin
          state_s = ST_WR_HI;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_RD_LO: begin
        if (avm_waitrequest) begin
          state_s = ST_RD_LO;
        end else begin
          state_s = ST_RD_HI;
        end
      end
      ST_RD_HI: begin
        if (last_beat_s) begin
          state_s = ST_RESP;
        end else if (avm_waitrequest) begin
          state_s = ST_RD_HI;
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (last_beat_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode purely from registered state and the latched request.
  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    avm_address    = '0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = 16'h0000;
    avm_byteenable = 2'b00;
    case (state_r)
      ST_IDLE: begin
        cpu_req_ready = 1'b1;
      end
      ST_WR_LO: begin
        avm_write      = 1'b1;
        avm_address    = {req_addr_r, HALF_LO};
        avm_writedata  = req_wdata_r[15:0];
        avm_byteenable = req_be_r[1:0];
      end
      ST_WR_HI: begin
        avm_write      = 1'b1;
        avm_address    = {req_addr_r, HALF_HI};
        avm_writedata  = req_wdata_r[31:16];
        avm_byteenable = req_be_r[3:2];
      end
      ST_RD_LO: begin
        avm_read       = 1'b1;
        avm_address    = {req_addr_r, HALF_LO};
        avm_byteenable = 2'b11;
      end
      ST_RD_HI: begin
        avm_read       = 1'b1;
        avm_address    = {req_addr_r, HALF_HI};
        avm_byteenable = 2'b11;
      end
      ST_RD_WAIT: begin
        cpu_resp_valid = 1'b0;
      end
      ST_RESP: begin
        cpu_resp_valid = 1'b1;
      end
      default: begin
        cpu_req_ready = 1'b0;
      end
    endcase
  end

  // Latch the request on acceptance; held for the whole transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_addr_r  <= '0;
      req_wdata_r <= 32'h0000_0000;
      req_be_r    <= 4'h0;
    end else if ((state_r == ST_IDLE) && cpu_req_valid) begin
      req_addr_r  <= cpu_req_addr;
      req_wdata_r <= cpu_req_wdata;
      req_be_r    <= cpu_req_be;
    end else begin
      req_addr_r  <= req_addr_r;
      req_wdata_r <= req_wdata_r;
      req_be_r    <= req_be_r;
    end
  end

  // Assemble read beats into the response word; first beat is the low half.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_r <= BEAT_FIRST;
      rdata_r    <= 32'h0000_0000;
    end else if (capture_s) begin
      if (beat_cnt_r == BEAT_FIRST) begin
        rdata_r[15:0] <= avm_readdata;
        beat_cnt_r    <= BEAT_SECOND;
      end else begin
        rdata_r[31:16] <= avm_readdata;
        beat_cnt_r     <= BEAT_FIRST;
      end
    end else if (state_r == ST_IDLE) begin
      beat_cnt_r <= BEAT_FIRST;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign cpu_resp_rdata = rdata_r;

endmodule

// File: tb/tb_cpu_sdram_bridge.sv
// Self-checking bench: CPU-level word memory reference plus an Avalon
// SDRAM slave model with random stalls and read latency.
module tb_cpu_sdram_bridge;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_ready;
  logic          cpu_req_we = 1'b0;
  logic [AW-1:0] cpu_req_addr = '0;
  logic [31:0]   cpu_req_wdata = 32'h0;
  logic [3:0]    cpu_req_be = 4'h0;
  logic          cpu_resp_valid;
  logic [31:0]   cpu_resp_rdata;
  logic [AW:0]   avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [15:0]   avm_writedata;
  logic [1:0]    avm_byteenable;
  logic          avm_waitrequest = 1'b0;
  logic [15:0]   avm_readdata = 16'h0;
  logic          avm_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  cpu_sdram_bridge #(.CPU_AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [AW:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } txn_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } beat_t;

  txn_t        exp_q[$];
  beat_t       rq[$];
  logic [15:0] sdram[int];
  logic [31:0] ref_mem[int];
  logic [31:0] last_rd = 32'h0;

  int cyc = 0;
  int rd_lat_lo = 1;
  int rd_lat_hi = 1;
  bit rand_lat = 1'b0;
  int wait_pct = 0;
  int force_wait = 0;
  bit stray_req = 1'b0;
  int beats_sent = 0;
  int last_due = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Avalon SDRAM slave: decides stalls, records accepted transfers, returns beats.
  always @(negedge clk) begin : slave
    logic [41:0] cur;
    logic [41:0] snap;
    bit          held;
    bit          stall;
    txn_t        t;
    txn_t        e;
    beat_t       b;
    logic [15:0] w;
    int          a;
    int          lat;
    int          due;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 16'h0;
    if (stray_req) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 16'hBAD0;
      stray_req         = 1'b0;
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      b = rq.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata      = b.d;
      beats_sent++;
    end
    cur = {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable};
    if (held && reset_n) chk("hold_stable", cur, snap);
    held = 1'b0;
    avm_waitrequest = 1'b0;
    if (reset_n && (avm_read || avm_write)) begin
      if (force_wait > 0) begin
        force_wait--;
        stall = 1'b1;
      end else begin
        stall = ($urandom_range(99) < wait_pct);
      end
      avm_waitrequest = stall;
      if (stall) begin
        held = 1'b1;
        snap = cur;
      end else begin
        t.wr = avm_write;
        t.a  = avm_address;
        t.d  = avm_write ? avm_writedata : 16'h0;
        t.be = avm_byteenable;
        if (exp_q.size() == 0) begin
          chk("unexpected_txn", {23'h0, t}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("avm_txn", {23'h0, t}, {23'h0, e});
        end
        a = int'(avm_address);
        w = sdram.exists(a) ? sdram[a] : 16'h0;
        if (avm_write) begin
          if (avm_byteenable[0]) w[7:0]  = avm_writedata[7:0];
          if (avm_byteenable[1]) w[15:8] = avm_writedata[15:8];
          sdram[a] = w;
        end else begin
          lat = rand_lat ? int'($urandom_range(4, 1)) : (avm_address[0] ? rd_lat_hi : rd_lat_lo);
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          rq.push_back('{due, w});
        end
      end
    end
  end

  // One CPU transaction: predict Avalon traffic and response, then check them.
  task automatic do_req(input bit we, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int exp_lat, input string tag);
    int          n;
    bit          got;
    int          wa;
    logic [31:0] word;
    @(negedge clk);
    chk({tag, "_ready"}, {63'h0, cpu_req_ready}, 64'h1);
    wa   = int'(addr);
    word = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
    if (we) begin
      if (be[1:0] != 2'b00) exp_q.push_back('{1'b1, {addr, 1'b0}, wd[15:0], be[1:0]});
      if (be[3:2] != 2'b00) exp_q.push_back('{1'b1, {addr, 1'b1}, wd[31:16], be[3:2]});
      for (int i = 0; i < 4; i++) if (be[i]) word[i*8 +: 8] = wd[i*8 +: 8];
      ref_mem[wa] = word;
    end else begin
      exp_q.push_back('{1'b0, {addr, 1'b0}, 16'h0, 2'b11});
      exp_q.push_back('{1'b0, {addr, 1'b1}, 16'h0, 2'b11});
    end
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wd;
    cpu_req_be    = be;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'($urandom_range(1));
    cpu_req_addr  = AW'($urandom);
    cpu_req_wdata = $urandom;
    cpu_req_be    = 4'($urandom);
    got = 1'b0;
    n   = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      got = cpu_resp_valid;
    end
    chk({tag, "_resp_seen"}, {63'h0, got}, 64'h1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    if (!we) last_rd = word;
    chk({tag, "_rdata"}, {32'h0, cpu_resp_rdata}, {32'h0, last_rd});
    chk({tag, "_txns_done"}, 64'(exp_q.size()), 64'h0);
    @(negedge clk);
    chk({tag, "_resp_pulse"}, {63'h0, cpu_resp_valid}, 64'h0);
    chk({tag, "_ready_back"}, {63'h0, cpu_req_ready}, 64'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'h0, cpu_req_ready}, 64'h1);
    chk({tag, "_resp"}, {63'h0, cpu_resp_valid}, 64'h0);
    chk({tag, "_rdata"}, {32'h0, cpu_resp_rdata}, 64'h0);
    chk({tag, "_avm"}, {22'h0, avm_read, avm_write, avm_address, avm_writedata, avm_byteenable}, 64'h0);
  endtask

  logic [AW-1:0] ones;
  int            b0;
  int            n;

  initial begin
    ones = '1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    #2 reset_n = 1'b1;

    // 1: full write, no stalls
    do_req(1'b1, 21'h000010, 32'hDEADBEEF, 4'hF, 3, "t1_wr");
    // 2: read back, controller latency 1
    rd_lat_lo = 1; rd_lat_hi = 1;
    do_req(1'b0, 21'h000010, 32'h0, 4'h0, 4, "t2_rd");
    // 3: upper-half write held off by four stall cycles
    force_wait = 4;
    do_req(1'b1, 21'h000010, 32'h12345678, 4'hC, 6, "t3_wr");
    // 4: no byte enables -> no Avalon traffic
    do_req(1'b1, 21'h000020, 32'hCAFEF00D, 4'h0, 1, "t4_wr");
    // 5: first beat during RD_HI, second three cycles later
    rd_lat_lo = 1; rd_lat_hi = 3;
    do_req(1'b0, 21'h000010, 32'h0, 4'h0, 6, "t5_rd");
    // Address wrap at the top of the space
    do_req(1'b1, ones, 32'hA5A55A5A, 4'hF, 3, "wrap_wr");
    do_req(1'b0, ones, 32'h0, 4'h0, -1, "wrap_rd");

    // 6: reset between the two read beats, then a stray beat
    rd_lat_lo = 1; rd_lat_hi = 6;
    @(negedge clk);
    exp_q.push_back('{1'b0, {21'h000010, 1'b0}, 16'h0, 2'b11});
    exp_q.push_back('{1'b0, {21'h000010, 1'b1}, 16'h0, 2'b11});
    b0 = beats_sent;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 21'h000010; cpu_req_be = 4'hF;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    n = 0;
    while (beats_sent == b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_beat1_seen", 64'(beats_sent - b0), 64'h1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("t6_reset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    n = 0;
    while (rq.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
      chk("t6_drain_resp", {63'h0, cpu_resp_valid}, 64'h0);
    end
    chk("t6_drained", 64'(rq.size()), 64'h0);
    @(negedge clk);
    stray_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("t6_stray");
    end
    last_rd = 32'h0;
    rd_lat_lo = 2; rd_lat_hi = 2;
    do_req(1'b0, 21'h000010, 32'h0, 4'h0, 5, "t6_rd");

    // Randomised mix with stalls and variable latency
    wait_pct = 30;
    rand_lat = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] ra;
      case ($urandom_range(5))
        0: ra = 21'h0;
        1: ra = 21'h1;
        2: ra = 21'h2;
        3: ra = ones;
        4: ra = 21'h000010;
        default: ra = AW'($urandom);
      endcase
      do_req(1'($urandom_range(1)), ra, $urandom, 4'($urandom), -1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sdram_bridge.md
Name: cpu_sdram_bridge

Overview:
Converts single-outstanding 32-bit CPU word requests into pairs of 16-bit Avalon-MM transactions for the SDRAM controller inside top. The controller drives the 16-bit DRAM_DQ bus.
Sits between the CPU memory port and the SDRAM controller's slave port. It handles waitrequest back-pressure and pipelined readdatavalid returns, and returns one response per CPU request.

Parameters:
CPU_AW, 21, CPU word-address width; Avalon half-word address width is CPU_AW+1 (21 -> 8 MB SDRAM).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  bridge accepts request (high only in IDLE)
cpu_req_we  in  1  1 = write, 0 = read
cpu_req_addr  in  CPU_AW  word address
cpu_req_wdata  in  32  write data
cpu_req_be  in  4  byte enables, bit n = byte n
cpu_resp_valid  out  1  one-cycle response pulse (reads and writes)
cpu_resp_rdata  out  32  read data, valid with cpu_resp_valid on reads
avm_address  out  CPU_AW+1  half-word address to SDRAM controller
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  16  Avalon write data
avm_byteenable  out  2  Avalon byte enables, active high
avm_waitrequest  in  1  controller stall
avm_readdata  in  16  read data
avm_readdatavalid  in  1  read data beat valid

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0 except cpu_req_ready=1, beat counter 0, cpu_resp_rdata 0.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_WAIT, RESP. All outputs decode from registered state and latched request; there are no combinational paths from cpu_* inputs.
- IDLE: on valid&ready at an edge, latch addr/wdata/be/we.
  - Write next state: WR_LO if be[1:0]!=0; else WR_HI if be[3:2]!=0; else RESP.
  - Read next state: RD_LO.
- WR_LO drives avm_write=1, avm_address={addr,1'b0}, writedata=wdata[15:0], byteenable=be[1:0].
  - Stays in WR_LO while avm_waitrequest=1.
  - When waitrequest=0, goes to WR_HI if be[3:2]!=0, else RESP.
- WR_HI drives address {addr,1'b1}, writedata=wdata[31:16], byteenable=be[3:2]. When waitrequest=0, goes to RESP.
- RD_LO drives avm_read=1, address {addr,0}, byteenable=2'b11. When waitrequest=0, goes to RD_HI.
- RD_HI drives avm_read=1, address {addr,1}. When waitrequest=0, goes to RD_WAIT.
- Beat counter (2 bits), active in RD_LO/RD_HI/RD_WAIT:
  - each readdatavalid captures readdata into the rdata half selected by the counter (0 -> [15:0], 1 -> [31:16]), then increments.
  - Beats may arrive while still in RD_HI; they are still counted.
  - When the second beat is captured, state goes to RESP from RD_HI or RD_WAIT, and the counter clears.
- RESP: cpu_resp_valid=1 for exactly one cycle, then IDLE.
  - cpu_resp_rdata updates only on reads and holds its value otherwise, including across write responses.
- Avalon request signals are held stable while waitrequest=1. At most two reads are outstanding.
- readdatavalid outside read states is ignored. This covers beats still in flight from a read interrupted by reset.
- be=4'b0000 write: no Avalon traffic, resp_valid the cycle after acceptance.
- Address wrap: addr all-ones maps to half-words 2^(CPU_AW+1)-2 and -1. There is no carry and no wrap logic.
- Minimum latency, acceptance edge to resp_valid:
  - full write: 3 cycles.
  - read: 2 + controller read latency + 1 cycle.

Decomposition:
- Shared package cpu_sdram_pkg: state enum, HALF_LO/HALF_HI constants, CPU_AW default.
- Single module, no sub-module. The datapath is a 32-bit assembly register plus a mux and does not justify one.

Test Plan:
1. Write addr=0x000010, wdata=0xDEADBEEF, be=0xF, no waitrequest -> Avalon writes (0x000020, 0xBEEF, 2'b11), then (0x000021, 0xDEAD, 2'b11) on consecutive cycles; resp_valid 3 cycles after acceptance.
2. Read addr=0x000010 against the SDRAM model after test 1 -> two reads at 0x20/0x21; resp_rdata=0xDEADBEEF with single-cycle resp_valid.
3. Write be=0xC, wdata=0x12345678 with waitrequest high for 4 cycles -> WR_LO skipped; one write (0x21, 0x1234, 2'b11) held stable for 4 cycles; rdata unchanged.
4. Write be=0x0 -> no avm_write, resp_valid next cycle.
5. Read where beat 1 arrives during RD_HI and beat 2 three cycles later -> both halves assembled in order; exactly one resp_valid.
6. Assert reset_n low between the two readdatavalid beats, release, then inject a stray readdatavalid -> outputs return to reset values; stray beat ignored; next read returns correct data.
